// File: rtl/streamcalc_pkg.sv
// Shared definitions for the stream calculator and its program sequencer:
// op codes and the sequencer FSM encoding.
package streamcalc_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_DIV  = 3'd3;
  localparam logic [2:0] OP_MOD  = 3'd4;
  localparam logic [2:0] OP_PUSH = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_DONE,
    ST_ERR
  } state_t;

  // States in which the host may load, clear or start a run.
  function automatic logic is_quiescent(input state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_ERR);
  endfunction

endpackage

// File: rtl/streamcalc_driver_prog_buffer.sv
// Token store for the sequencer: append-only write side whose pointer is the
// token count, plus an independent replay read pointer.
module prog_buffer #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_clear,
  input  logic                     i_wr_en,
  input  logic [2:0]               i_wr_op,
  input  logic [W-1:0]             i_wr_data,
  input  logic                     i_rd_rst,
  input  logic                     i_rd_inc,
  output logic [2:0]               o_rd_op,
  output logic [W-1:0]             o_rd_data,
  output logic [$clog2(DEPTH)-1:0] o_rd_ptr,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [2:0]   r_op   [DEPTH];
  logic [W-1:0] r_data [DEPTH];
  logic [AW:0]  r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic         w_wr;

  assign w_wr = i_wr_en & ~o_full;

  always_ff @(posedge clk) begin
    if (rst || i_clear)
      r_wr_ptr <= '0;
    else if (w_wr)
      r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst || i_rd_rst)
      r_rd_ptr <= '0;
    else if (i_rd_inc)
      r_rd_ptr <= r_rd_ptr + AW'(1);
  end

  // Storage carries no reset; the write pointer alone defines valid contents.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_op[r_wr_ptr[AW-1:0]]   <= i_wr_op;
      r_data[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end
  end

  assign o_rd_op   = r_op[r_rd_ptr];
  assign o_rd_data = r_data[r_rd_ptr];
  assign o_rd_ptr  = r_rd_ptr;
  assign o_count   = r_wr_ptr;
  assign o_full    = r_wr_ptr[AW];
  assign o_empty   = (r_wr_ptr == '0);

endmodule

// File: rtl/streamcalc_driver.sv
// Program sequencer for the stream calculator: replays a stored RPN token
// program into the calculator and reports its final top of stack or a fault.
module streamcalc_driver
  import streamcalc_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic [2:0]   load_op,
  input  logic [W-1:0] load_data,
  input  logic         clear,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [W-1:0] result,
  output logic         calc_rst,
  output logic         calc_apply,
  output logic [2:0]   calc_op,
  output logic [W-1:0] calc_in,
  input  logic [W-1:0] calc_tail,
  input  logic         calc_empty,
  input  logic         calc_valid
);
  localparam int AW = $clog2(DEPTH);

  state_t        r_state, w_next;
  logic [W-1:0]  r_result;
  logic          w_quiet, w_load_acc, w_buf_clr, w_last;
  logic          w_rd_rst, w_rd_inc, w_apply, w_capture;
  logic [2:0]    w_rd_op;
  logic [W-1:0]  w_rd_data;
  logic [AW-1:0] w_rd_ptr;
  logic [AW:0]   w_count;
  logic          w_full, w_empty;

  assign w_quiet    = is_quiescent(r_state);
  assign load_ready = w_quiet & ~w_full & ~start & ~clear;
  assign w_load_acc = load_valid & load_ready;
  assign w_buf_clr  = w_quiet & clear;
  assign w_last     = ({1'b0, w_rd_ptr} == (w_count - (AW+1)'(1)));

  prog_buffer #(.W(W), .DEPTH(DEPTH)) u_buf (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_buf_clr),
    .i_wr_en   (w_load_acc),
    .i_wr_op   (load_op),
    .i_wr_data (load_data),
    .i_rd_rst  (w_rd_rst),
    .i_rd_inc  (w_rd_inc),
    .o_rd_op   (w_rd_op),
    .o_rd_data (w_rd_data),
    .o_rd_ptr  (w_rd_ptr),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst)            r_result <= '0;
    else if (w_capture) r_result <= calc_tail;
  end

  always_comb begin
    w_next    = r_state;
    w_rd_rst  = 1'b0;
    w_rd_inc  = 1'b0;
    w_apply   = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (clear)                 w_next = ST_IDLE;
        else if (start && !w_empty) w_next = ST_CLEAR;
        else if (w_load_acc)       w_next = ST_IDLE;
      end
      ST_CLEAR: begin
        w_rd_rst = 1'b1;
        w_next   = ST_RUN;
      end
      ST_RUN: begin
        // calc_valid lags one token, so it is only meaningful after the first.
        if ((w_rd_ptr != '0) && !calc_valid) begin
          w_next = ST_ERR;
        end else begin
          w_apply  = 1'b1;
          w_rd_inc = 1'b1;
          if (w_last) w_next = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (calc_valid && !calc_empty) begin
          w_capture = 1'b1;
          w_next    = ST_DONE;
        end else begin
          w_next = ST_ERR;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy       = (r_state == ST_CLEAR) | (r_state == ST_RUN) | (r_state == ST_SETTLE);
  assign done       = (r_state == ST_DONE);
  assign error      = (r_state == ST_ERR);
  assign result     = r_result;
  assign calc_rst   = rst | (r_state == ST_CLEAR);
  assign calc_apply = w_apply;
  assign calc_op    = w_apply ? w_rd_op : OP_PUSH;
  assign calc_in    = w_apply ? w_rd_data : '0;

endmodule

// File: tb/tb_streamcalc_driver.sv
// Directed bench for streamcalc_driver with a behavioural stream calculator
// attached to the calc_* port.
module tb_streamcalc_driver;
  import streamcalc_pkg::*;

  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst, load_valid, clear, start;
  logic [2:0]   load_op;
  logic [W-1:0] load_data;
  logic         load_ready, busy, done, error;
  logic [W-1:0] result;
  logic         calc_rst, calc_apply;
  logic [2:0]   calc_op;
  logic [W-1:0] calc_in, calc_tail;
  logic         calc_empty, calc_valid;

  int n_pass = 0;
  int n_chk  = 0;

  always #5 clk = ~clk;

  streamcalc_driver #(.W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .load_valid(load_valid), .load_ready(load_ready),
    .load_op(load_op), .load_data(load_data),
    .clear(clear), .start(start),
    .busy(busy), .done(done), .error(error), .result(result),
    .calc_rst(calc_rst), .calc_apply(calc_apply),
    .calc_op(calc_op), .calc_in(calc_in),
    .calc_tail(calc_tail), .calc_empty(calc_empty), .calc_valid(calc_valid)
  );

  // Behavioural calculator: registered stack, valid drops on underflow or /0.
  logic [W-1:0] c_stk [32];
  int           c_sp;
  logic         c_valid;

  function automatic logic [W-1:0] calc_fn(input logic [2:0] op,
                                           input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a * b;
      3'd3:    return b / a;
      default: return b % a;
    endcase
  endfunction

  always @(posedge clk) begin
    if (calc_rst) begin
      c_sp    <= 0;
      c_valid <= 1'b1;
    end else if (calc_apply && c_valid) begin
      if (calc_op > 3'd4) begin
        c_stk[c_sp] <= calc_in;
        c_sp        <= c_sp + 1;
      end else if (c_sp < 2) begin
        c_valid <= 1'b0;
      end else if (calc_op >= 3'd3 && c_stk[c_sp-1] == '0) begin
        c_valid <= 1'b0;
      end else begin
        c_stk[c_sp-2] <= calc_fn(calc_op, c_stk[c_sp-1], c_stk[c_sp-2]);
        c_sp          <= c_sp - 1;
      end
    end
  end

  assign calc_tail  = (c_sp > 0) ? c_stk[c_sp-1] : '0;
  assign calc_empty = (c_sp == 0);
  assign calc_valid = c_valid;

  typedef struct packed {
    logic [1:0]        n;
    logic [2:0][2:0]   op;
    logic [2:0][W-1:0] d;
    logic [4:0]        lat;
    logic              ok;
    logic              err;
    logic [W-1:0]      res;
  } vec_t;

  function automatic vec_t mk(input int n,
                              input logic [2:0] o0, input int d0,
                              input logic [2:0] o1, input int d1,
                              input logic [2:0] o2, input int d2,
                              input int lat, input logic ok, input logic err, input int res);
    vec_t v;
    v.n = 2'(n);
    v.op[0] = o0; v.d[0] = W'(d0);
    v.op[1] = o1; v.d[1] = W'(d1);
    v.op[2] = o2; v.d[2] = W'(d2);
    v.lat = 5'(lat); v.ok = ok; v.err = err; v.res = W'(res);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Optionally reloads the program, then starts it and checks the whole run.
  task automatic run_vec(input string tag, input vec_t v, input bit do_load);
    int first, nap, bad;
    if (do_load) begin
      clear = 1'b1; tick(); clear = 1'b0;
      for (int i = 0; i < int'(v.n); i++) begin
        load_valid = 1'b1; load_op = v.op[i]; load_data = v.d[i];
        tick();
      end
      load_valid = 1'b0;
    end
    start = 1'b1; tick(); start = 1'b0;
    chk({tag, " clear_cycle"}, calc_rst, 1);
    chk({tag, " busy_k1"}, {busy, done, error}, 3'b100);
    first = 0; nap = 0; bad = 0;
    for (int c = 2; c <= 40 && first == 0; c++) begin
      tick();
      if (calc_apply) begin
        if (nap >= int'(v.n) || calc_op !== v.op[nap] || calc_in !== v.d[nap]) bad++;
        nap++;
      end else if (calc_op !== OP_PUSH || calc_in !== '0) begin
        bad++;
      end
      if (done || error) first = c;
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      if (calc_apply || calc_op !== OP_PUSH || calc_in !== '0) bad++;
    end
    chk({tag, " latency"}, first, v.lat);
    chk({tag, " done"}, done, v.ok);
    chk({tag, " error"}, error, v.err);
    if (v.ok) chk({tag, " result"}, result, v.res);
    if (!v.err) chk({tag, " apply_count"}, nap, v.n);
    chk({tag, " drive"}, bad, 0);
  endtask

  vec_t vecs[12];

  initial begin
    int first, nap;
    vecs[0]  = mk(3, OP_PUSH, 7,   OP_PUSH, 5,  OP_ADD, 0, 6, 1, 0, 12);
    vecs[1]  = mk(3, OP_PUSH, 6,   OP_PUSH, 3,  OP_DIV, 0, 6, 1, 0, 2);
    vecs[2]  = mk(3, OP_PUSH, 4,   OP_PUSH, 0,  OP_DIV, 0, 6, 0, 1, 0);
    vecs[3]  = mk(3, OP_PUSH, 3,   OP_PUSH, 10, OP_SUB, 0, 6, 1, 0, 7);
    vecs[4]  = mk(3, OP_PUSH, 20,  OP_PUSH, 15, OP_MUL, 0, 6, 1, 0, 44);
    vecs[5]  = mk(3, OP_PUSH, 17,  OP_PUSH, 5,  OP_MOD, 0, 6, 1, 0, 2);
    vecs[6]  = mk(3, OP_PUSH, 250, OP_PUSH, 10, OP_ADD, 0, 6, 1, 0, 4);
    vecs[7]  = mk(3, OP_PUSH, 10,  OP_PUSH, 3,  OP_SUB, 0, 6, 1, 0, 249);
    vecs[8]  = mk(1, OP_PUSH, 9,   OP_PUSH, 0,  OP_PUSH, 0, 4, 1, 0, 9);
    vecs[9]  = mk(1, OP_ADD, 0,    OP_PUSH, 0,  OP_PUSH, 0, 4, 0, 1, 0);
    vecs[10] = mk(3, OP_ADD, 0,    OP_PUSH, 1,  OP_PUSH, 2, 4, 0, 1, 0);
    vecs[11] = mk(2, 3'd6, 33,     3'd7, 44,    OP_PUSH, 0, 5, 1, 0, 44);

    rst = 1'b1; load_valid = 1'b0; clear = 1'b0; start = 1'b0;
    load_op = '0; load_data = '0;
    tick(); tick();
    chk("rst load_ready", load_ready, 1);
    chk("rst calc_rst", calc_rst, 1);
    chk("rst flags", {busy, done, error, calc_apply}, 4'b0000);
    chk("rst result", result, 0);
    chk("rst calc_in", calc_in, 0);
    rst = 1'b0;
    tick();
    chk("idle calc_rst", calc_rst, 0);

    for (int i = 0; i < 12; i++) run_vec($sformatf("vec%0d", i), vecs[i], 1'b1);

    // Replay the stored DIV program without reloading.
    run_vec("load_div", vecs[1], 1'b1);
    run_vec("replay_div", vecs[1], 1'b0);
    load_valid = 1'b1; load_op = OP_PUSH; load_data = 8'd1;
    tick(); load_valid = 1'b0;
    chk("load_drops_done", done, 0);

    // Fill to capacity, then offer a 17th token.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      load_valid = 1'b1; load_op = OP_PUSH; load_data = W'(i + 1);
      tick();
    end
    load_data = 8'd99;
    chk("full_ready", load_ready, 0);
    tick(); load_valid = 1'b0;
    chk("full_hold", load_ready, 0);
    start = 1'b1; tick(); start = 1'b0;
    first = 0; nap = 0;
    for (int c = 2; c <= 40 && first == 0; c++) begin
      tick();
      if (calc_apply) nap++;
      if (done || error) first = c;
    end
    chk("full latency", first, DEPTH + 3);
    chk("full apply_count", nap, DEPTH);
    chk("full done", done, 1);
    chk("full result", result, DEPTH);

    // Start on an empty buffer, colliding with a load.
    clear = 1'b1; tick(); clear = 1'b0;
    chk("clear_drops_done", done, 0);
    start = 1'b1; load_valid = 1'b1; load_op = OP_PUSH; load_data = 8'd1;
    #1 chk("ready_vs_start", load_ready, 0);
    tick(); start = 1'b0; load_valid = 1'b0;
    chk("empty_start busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("load_dropped", busy, 0);

    // Clear beats start, and really empties the buffer.
    load_valid = 1'b1; load_op = OP_PUSH; load_data = 8'd5;
    tick(); load_valid = 1'b0;
    clear = 1'b1; start = 1'b1;
    tick(); clear = 1'b0; start = 1'b0;
    chk("clear_vs_start busy", busy, 0);
    start = 1'b1; tick(); start = 1'b0;
    chk("clear_emptied", busy, 0);

    // Reset in the second RUN cycle.
    for (int i = 0; i < 3; i++) begin
      load_valid = 1'b1; load_op = vecs[0].op[i]; load_data = vecs[0].d[i];
      tick();
    end
    load_valid = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("run2 apply", calc_apply, 1);
    rst = 1'b1;
    #1 chk("rst_comb calc_rst", calc_rst, 1);
    tick();
    chk("midrst flags", {busy, done, error, calc_apply, load_ready, calc_rst}, 6'b000011);
    chk("midrst result", result, 0);
    rst = 1'b0;
    tick();
    chk("post_rst quiet", {busy, calc_apply, calc_rst}, 3'b000);
    start = 1'b1; tick(); start = 1'b0;
    chk("midrst buffer_empty", busy, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/streamcalc_driver.md
# streamcalc_driver

Program sequencer that acts as the initiator for the stream calculator. It stores a short RPN program of (op, operand) tokens loaded by a host. On `start` it clears the calculator, issues one token per cycle on the calculator's `apply/op/in` port, and monitors `valid` throughout. When the run ends it reports the calculator's top-of-stack `tail` as `result`, or raises `error`.

## Interface
- `W`, 8: data width; must match the calculator's `W`.
- `DEPTH`, 16: program buffer capacity in tokens, a power of two.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `load_valid`  in  1  host offers one token.
- `load_ready`  out  1  token accepted on a cycle with `load_valid & load_ready`.
- `load_op`  in  3  token op code.
- `load_data`  in  W  token operand; used only by push.
- `clear`  in  1  empties the program buffer; ignored while `busy`.
- `start`  in  1  single-cycle run request.
- `busy`  out  1  high in CLEAR, RUN and SETTLE.
- `done`  out  1  run finished without error; held until the next run, load, clear or reset.
- `error`  out  1  run aborted; held like `done`.
- `result`  out  W  calculator `tail` captured on the transition to DONE.
- `calc_rst`  out  1  drives the calculator's reset.
- `calc_apply`  out  1  token strobe.
- `calc_op`  out  3  token op code.
- `calc_in`  out  W  token operand.
- `calc_tail`  in  W  calculator top of stack.
- `calc_empty`  in  1  calculator stack empty.
- `calc_valid`  in  1  calculator status; low means a fault occurred.

## Operation
- Op codes:
  - 0 ADD: first+second.
  - 1 SUB: first−second.
  - 2 MUL: first*second.
  - 3 DIV: second/first.
  - 4 MOD: second%first.
  - 5 PUSH: push `load_data`.
  - `first` is the most recently pushed element.
- Op codes 6 and 7 are stored and issued unchanged; the calculator treats them as push.
- Arithmetic is performed by the calculator, modulo 2^W. The driver never inspects operands.
- FSM states: IDLE, CLEAR, RUN, SETTLE, DONE, ERR.
- IDLE/DONE/ERR:
  - Loads are accepted.
  - An accepted load or `clear` in DONE or ERR moves to IDLE and drops `done`/`error`.
  - `start` with count>0 moves to CLEAR. `start` with count==0 is ignored.
- CLEAR: one cycle with `calc_rst`=1; read pointer reset to 0; then RUN.
- RUN:
  - `calc_apply`=1, with `calc_op`/`calc_in` taken from buffer[rd_ptr]. rd_ptr increments each cycle.
  - After issuing token count−1, moves to SETTLE.
  - If `calc_valid`=0 in any RUN cycle after the first, moves to ERR and stops issuing.
- SETTLE:
  - One cycle with `calc_apply`=0.
  - If `calc_valid`=1 and `calc_empty`=0: move to DONE and capture `result`.
  - Otherwise: move to ERR.
- The program buffer is non-destructive, so `start` in DONE or ERR replays the same program.
- `load_ready` = (state ∈ {IDLE, DONE, ERR}) & count<DEPTH & !`start` & !`clear`.
- Simultaneous events:
  - `start` with `load_valid`: start wins and the load is not accepted.
  - `clear` with `start`: clear wins and the run does not begin.
- When full (count==DEPTH), `load_ready`=0 and the buffer is unchanged.

## Timing
- Reset values:
  - Outputs: `load_ready`=1, `calc_rst`=1 (combinationally OR'd with `rst`), and every other output 0, including `result`.
  - Internal: count=0, state IDLE.
- Reset mid-run: return to IDLE within the same edge, with the buffer emptied and no further `calc_apply`.
- Run latency for N tokens, with `start` sampled at edge k:
  - CLEAR in cycle k+1.
  - RUN in cycles k+2 … k+N+1.
  - SETTLE in cycle k+N+2.
  - `done` or `error` high from cycle k+N+3.
- `calc_op`/`calc_in` are registered or muxed from the buffer and are stable for the whole cycle in which `calc_apply` is high.
- When `calc_apply`=0, `calc_op` = 5 and `calc_in` = 0.

## Structure
- `streamcalc_pkg`: op-code constants `OP_ADD`…`OP_PUSH` and the FSM state encoding. This package is shared with the calculator.
- Sub-module `prog_buffer`:
  - DEPTH×(3+W) register array.
  - Write pointer doubles as count; separate replay read pointer.
  - Provides full/empty and clear.
- The top level holds the FSM, the `calc_*` drive logic and the `result` register.

## Test plan
- Load PUSH 7, PUSH 5, ADD; `start` at k → RUN for 3 cycles, `done`=1 at k+6, `result`=12.
- Load PUSH 6, PUSH 3, DIV → `result`=2. Replay with a second `start` → same `result`, and `done` drops during `busy`.
- Load PUSH 4, PUSH 0, DIV → `error`=1 and `done`=0; `calc_apply` stays low after the abort.
- Load 16 tokens → `load_ready`=0. A 17th `load_valid` is not stored; count stays 16.
- `start` with an empty buffer → stays IDLE and `busy` stays 0. `start` together with `load_valid` → load dropped.
- Pulse `rst` in the second RUN cycle → all outputs reset next cycle, the buffer is empty and `calc_rst`=1.
